// File: rtl/vga_timing_gen_if.sv
// Video port bundle: pattern controls in, sync/RGB/coordinates out.
interface vga_timing_gen_if;
    logic [1:0]  mode;
    logic [7:0]  solid_color;
    logic        hs;
    logic        vs;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame_start;

    // Generator side drives timing and colour, samples the pattern controls.
    modport master (
        input  mode, solid_color,
        output hs, vs, r, g, b, de, x, y, frame_start
    );

    // Consumer side (DAC pins, frame-buffer reader, bench).
    modport slave (
        output mode, solid_color,
        input  hs, vs, r, g, b, de, x, y, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing and test-pattern generator with registered, zero-skew outputs.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FP    = 10,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    vga_timing_gen_if.master vif
);
    localparam int unsigned CW      = 11;
    localparam int unsigned CMP_W   = 12;
    localparam int unsigned DW      = 4;
    localparam int unsigned H_TOT   = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOT   = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_ACT_S = H_SYNC + H_BP;
    localparam int unsigned H_ACT_E = H_ACT_S + H_ACT;
    localparam int unsigned V_ACT_S = V_SYNC + V_BP;
    localparam int unsigned V_ACT_E = V_ACT_S + V_ACT;
    localparam int unsigned BAR_W   = H_ACT / 8;

    logic [DW-1:0] r_dc;
    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic [1:0]    r_mode;
    logic [7:0]    r_color;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [7:0]    r_rgb;
    logic          r_frame_start;

    logic          w_pix_en;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_first;
    logic          w_hs;
    logic          w_vs;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_de;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic [2:0]    w_bar;
    logic [2:0]    w_bar_c;
    logic          w_border;
    logic [7:0]    w_rgb;

    // With CLK_DIV=1 the divider sits at 0 and the compare holds every clock.
    assign w_pix_en      = (r_dc == DW'(CLK_DIV - 1));
    assign w_h_last      = (r_hc == CW'(H_TOT - 1));
    assign w_v_last      = (r_vc == CW'(V_TOT - 1));
    assign w_frame_first = (r_hc == '0) && (r_vc == '0);

    // Pixel-rate divider
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dc <= '0;
        end else if (w_pix_en) begin
            r_dc <= '0;
        end else begin
            r_dc <= r_dc + DW'(1);
        end
    end

    // Horizontal and vertical raster counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_hc <= '0;
                r_vc <= w_v_last ? '0 : r_vc + CW'(1);
            end else begin
                r_hc <= r_hc + CW'(1);
            end
        end
    end

    // Pattern controls only change at the frame boundary
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode  <= '0;
            r_color <= '0;
        end else if (w_pix_en && w_frame_first) begin
            r_mode  <= vif.mode;
            r_color <= vif.solid_color;
        end
    end

    // Decode sync, active window and coordinates from the current counters
    always_comb begin
        w_hs    = (CMP_W'(r_hc) < CMP_W'(H_SYNC)) ? HS_POL : ~HS_POL;
        w_vs    = (CMP_W'(r_vc) < CMP_W'(V_SYNC)) ? VS_POL : ~VS_POL;
        w_h_act = (CMP_W'(r_hc) >= CMP_W'(H_ACT_S)) && (CMP_W'(r_hc) < CMP_W'(H_ACT_E));
        w_v_act = (CMP_W'(r_vc) >= CMP_W'(V_ACT_S)) && (CMP_W'(r_vc) < CMP_W'(V_ACT_E));
        w_de    = w_h_act && w_v_act;
        w_x     = w_de ? (r_hc - CW'(H_ACT_S)) : '0;
        w_y     = w_de ? (r_vc - CW'(V_ACT_S)) : '0;
    end

    // Test-pattern colour; bars use threshold compares instead of a divider
    always_comb begin
        w_bar = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (CMP_W'(w_x) >= CMP_W'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
        w_bar_c  = 3'd7 - w_bar;
        w_border = (w_x == '0) || (w_x == CW'(H_ACT - 1)) ||
                   (w_y == '0) || (w_y == CW'(V_ACT - 1));
        w_rgb    = '0;
        if (w_de) begin
            case (r_mode)
                2'd0:    w_rgb = r_color;
                2'd1:    w_rgb = {{3{w_bar_c[2]}}, {3{w_bar_c[1]}}, {2{w_bar_c[0]}}};
                2'd2:    w_rgb = (w_x[5] ^ w_y[5]) ? 8'hFF : 8'h00;
                default: w_rgb = w_border ? 8'hFF : r_color;
            endcase
        end
    end

    // Output registers, all advancing together on the pixel enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_de  <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_rgb <= '0;
        end else if (w_pix_en) begin
            r_hs  <= w_hs;
            r_vs  <= w_vs;
            r_de  <= w_de;
            r_x   <= w_x;
            r_y   <= w_y;
            r_rgb <= w_rgb;
        end
    end

    // Frame-start strobe, exactly one system clock wide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pix_en && w_frame_first;
        end
    end

    assign vif.hs          = r_hs;
    assign vif.vs          = r_vs;
    assign vif.de          = r_de;
    assign vif.x           = r_x;
    assign vif.y           = r_y;
    assign vif.r           = r_rgb[7:5];
    assign vif.g           = r_rgb[4:2];
    assign vif.b           = r_rgb[1:0];
    assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-H/short-V generator (pattern scoreboard) plus a tiny CLK_DIV=1 generator (reset restart).
module tb_vga_timing_gen;
    localparam int A_HACT = 640;
    localparam int A_VACT = 4;
    localparam int B_HACT = 16;
    localparam int B_VACT = 8;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  rgb;
    } smp_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] color;
    } cfg_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  rgb;
    } probe_t;

    typedef struct {
        int n_clk;
        int hs_act;
        int vs_act;
        int de_clk;
        int de_lines;
        int rgb_err;
        int seq_err;
        int hs_run0;
        int line_per;
    } fstat_t;

    logic clock;
    logic rst_a;
    logic rst_b;
    logic done_a;
    logic done_b;
    int   n_total;
    int   n_bad;

    cfg_t   cfg_q[$];
    probe_t probe_q[$];

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen #(
        .CLK_DIV(2), .V_SYNC(2), .V_BP(1), .V_ACT(A_VACT), .V_FP(1)
    ) u_dut_a (
        .clock (clock),
        .reset (rst_a),
        .vif   (ifa)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(8), .H_BP(4), .H_ACT(B_HACT), .H_FP(4),
        .V_SYNC(2), .V_BP(2), .V_ACT(B_VACT), .V_FP(2), .HS_POL(1'b1)
    ) u_dut_b (
        .clock (clock),
        .reset (rst_b),
        .vif   (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic smp_t grab(input int inst);
        smp_t s;
        if (inst == 0) begin
            s = '{ifa.hs, ifa.vs, ifa.de, ifa.frame_start, ifa.x, ifa.y, {ifa.r, ifa.g, ifa.b}};
        end else begin
            s = '{ifb.hs, ifb.vs, ifb.de, ifb.frame_start, ifb.x, ifb.y, {ifb.r, ifb.g, ifb.b}};
        end
        return s;
    endfunction

    task automatic step(input int inst, output smp_t s);
        @(posedge clock);
        #1;
        s = grab(inst);
    endtask

    // Reference colour straight from the pattern definitions
    function automatic logic [7:0] exp_rgb(input cfg_t c, input int hact, input int vact,
                                           input int x, input int y);
        logic [2:0] ci;
        case (c.mode)
            2'd0: return c.color;
            2'd1: begin
                ci = 3'(7 - x / (hact / 8));
                return {{3{ci[2]}}, {3{ci[1]}}, {2{ci[0]}}};
            end
            2'd2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
            default: return (x == 0 || x == hact - 1 || y == 0 || y == vact - 1) ? 8'hFF : c.color;
        endcase
    endfunction

    function automatic probe_t mk(input int x, input int y, input logic [7:0] rgb);
        probe_t p;
        p.x   = 11'(x);
        p.y   = 11'(y);
        p.rgb = rgb;
        return p;
    endfunction

    // Drive pattern controls for generator A and queue what frame f must show
    task automatic drive_cfg(input int f);
        cfg_t c;
        case (f)
            0:       c = '{2'd0, 8'h1C};
            1:       c = '{2'd1, 8'h1C};
            2:       c = '{2'd2, 8'h1C};
            default: c = '{2'd3, 8'hE0};
        endcase
        ifa.mode        = c.mode;
        ifa.solid_color = c.color;
        cfg_q.push_back(c);
        case (f)
            0: begin
                probe_q.push_back(mk(10, 0, 8'h1C));
                probe_q.push_back(mk(639, 3, 8'h1C));
            end
            1: begin
                probe_q.push_back(mk(0, 0, 8'hFF));
                probe_q.push_back(mk(79, 0, 8'hFF));
                probe_q.push_back(mk(80, 0, 8'hFC));
                probe_q.push_back(mk(639, 0, 8'h00));
                probe_q.push_back(mk(320, 2, 8'h1F));
            end
            2: begin
                probe_q.push_back(mk(0, 0, 8'h00));
                probe_q.push_back(mk(31, 0, 8'h00));
                probe_q.push_back(mk(32, 0, 8'hFF));
                probe_q.push_back(mk(64, 1, 8'h00));
                probe_q.push_back(mk(96, 3, 8'hFF));
            end
            default: begin
                probe_q.push_back(mk(0, 0, 8'hFF));
                probe_q.push_back(mk(5, 1, 8'hE0));
                probe_q.push_back(mk(0, 2, 8'hFF));
                probe_q.push_back(mk(639, 2, 8'hFF));
                probe_q.push_back(mk(5, 3, 8'hFF));
                probe_q.push_back(mk(639, 3, 8'hFF));
            end
        endcase
    endtask

    // Walk one frame from a frame_start sample up to the next one, gathering statistics
    task automatic run_frame(input int inst, input cfg_t cfg, input int next_frame,
                             inout smp_t cur, inout smp_t prev, output fstat_t st);
        int   hact;
        int   vact;
        logic hpol;
        int   lead0;
        int   lead1;
        int   run;
        logic run_done;
        logic sw_done;
        hact     = (inst == 0) ? A_HACT : B_HACT;
        vact     = (inst == 0) ? A_VACT : B_VACT;
        hpol     = (inst == 0) ? 1'b0 : 1'b1;
        st       = '{default: 0};
        lead0    = -1;
        lead1    = -1;
        run      = 0;
        run_done = 1'b0;
        sw_done  = 1'b0;
        do begin
            if (cur.hs == hpol) st.hs_act++;
            if (cur.vs == 1'b0) st.vs_act++;
            if (cur.hs == hpol && prev.hs != hpol) begin
                if (lead0 < 0) lead0 = st.n_clk;
                else if (lead1 < 0) lead1 = st.n_clk;
            end
            if (!run_done) begin
                if (cur.hs == hpol) run++;
                else if (run > 0) run_done = 1'b1;
            end
            if (cur.de) begin
                st.de_clk++;
                if (!prev.de) begin
                    if (cur.x != 11'd0 || cur.y != 11'(st.de_lines)) st.seq_err++;
                    st.de_lines++;
                end else if (cur.x != prev.x && cur.x != prev.x + 11'd1) begin
                    st.seq_err++;
                end
                if (cur.rgb != exp_rgb(cfg, hact, vact, int'(cur.x), int'(cur.y))) st.rgb_err++;
                if (inst == 0 && probe_q.size() > 0 &&
                    cur.x == probe_q[0].x && cur.y == probe_q[0].y) begin
                    check_eq($sformatf("pix(%0d,%0d)", cur.x, cur.y), 32'(cur.rgb), 32'(probe_q[0].rgb));
                    void'(probe_q.pop_front());
                end
                if (inst == 0 && next_frame >= 0 && !sw_done && cur.y == 11'd1) begin
                    drive_cfg(next_frame);
                    sw_done = 1'b1;
                end
            end else begin
                if (prev.de && prev.x != 11'(hact - 1)) st.seq_err++;
                if (cur.rgb != 8'h00 || cur.x != 11'd0 || cur.y != 11'd0) st.rgb_err++;
            end
            st.n_clk++;
            prev = cur;
            step(inst, cur);
        end while (!cur.fs && st.n_clk < 20000);
        st.hs_run0  = run;
        st.line_per = (lead1 >= 0) ? lead1 - lead0 : -1;
    endtask

    // Generator A: defaults horizontally, short frame, all four patterns
    initial begin : run_a
        smp_t   cur;
        smp_t   prev;
        fstat_t st;
        cfg_t   c;
        int     k;
        done_a = 1'b0;
        rst_a  = 1'b1;
        drive_cfg(0);
        repeat (3) @(posedge clock);
        #1;
        cur = grab(0);
        check_eq("a_rst_hs", 32'(cur.hs), 32'd1);
        check_eq("a_rst_vs", 32'(cur.vs), 32'd1);
        check_eq("a_rst_de", 32'(cur.de), 32'd0);
        check_eq("a_rst_rgb", 32'(cur.rgb), 32'd0);
        check_eq("a_rst_x", 32'(cur.x), 32'd0);
        check_eq("a_rst_y", 32'(cur.y), 32'd0);
        check_eq("a_rst_fs", 32'(cur.fs), 32'd0);
        @(negedge clock);
        rst_a = 1'b0;
        k = 0;
        do begin
            prev = cur;
            step(0, cur);
            k++;
        end while (!cur.fs && k < 10);
        check_eq("a_fs_edge", 32'(k), 32'd2);
        check_eq("a_hs_first", 32'(cur.hs), 32'd0);
        check_eq("a_vs_first", 32'(cur.vs), 32'd0);
        for (int f = 0; f < 4; f++) begin
            c = (cfg_q.size() > 0) ? cfg_q.pop_front() : '{2'd0, 8'h00};
            run_frame(0, c, (f < 3) ? f + 1 : -1, cur, prev, st);
            check_eq($sformatf("a_f%0d_clocks", f), 32'(st.n_clk), 32'd12800);
            check_eq($sformatf("a_f%0d_hs_low", f), 32'(st.hs_act), 32'd1536);
            check_eq($sformatf("a_f%0d_vs_low", f), 32'(st.vs_act), 32'd3200);
            check_eq($sformatf("a_f%0d_de_clk", f), 32'(st.de_clk), 32'd5120);
            check_eq($sformatf("a_f%0d_de_lines", f), 32'(st.de_lines), 32'd4);
            check_eq($sformatf("a_f%0d_rgb_err", f), 32'(st.rgb_err), 32'd0);
            check_eq($sformatf("a_f%0d_xy_seq_err", f), 32'(st.seq_err), 32'd0);
            if (f == 0) begin
                check_eq("a_line_period", 32'(st.line_per), 32'd1600);
                check_eq("a_hs_width", 32'(st.hs_run0), 32'd192);
            end
        end
        check_eq("a_probes_left", 32'(probe_q.size()), 32'd0);
        check_eq("a_cfg_left", 32'(cfg_q.size()), 32'd0);
        done_a = 1'b1;
    end

    // Generator B: CLK_DIV=1, active-high hsync, reset asserted mid-line
    initial begin : run_b
        smp_t   cur;
        smp_t   prev;
        fstat_t st;
        cfg_t   c;
        int     k;
        done_b          = 1'b0;
        rst_b           = 1'b1;
        ifb.mode        = 2'd0;
        ifb.solid_color = 8'h1C;
        c               = '{2'd0, 8'h1C};
        repeat (3) @(posedge clock);
        #1;
        cur = grab(1);
        check_eq("b_rst_hs", 32'(cur.hs), 32'd0);
        check_eq("b_rst_vs", 32'(cur.vs), 32'd1);
        check_eq("b_rst_de", 32'(cur.de), 32'd0);
        @(negedge clock);
        rst_b = 1'b0;
        k = 0;
        do begin
            prev = cur;
            step(1, cur);
            k++;
        end while (!cur.fs && k < 10);
        check_eq("b_fs_edge", 32'(k), 32'd1);
        run_frame(1, c, -1, cur, prev, st);
        check_eq("b_clocks", 32'(st.n_clk), 32'd448);
        check_eq("b_line_period", 32'(st.line_per), 32'd32);
        check_eq("b_hs_width", 32'(st.hs_run0), 32'd8);
        check_eq("b_hs_high", 32'(st.hs_act), 32'd112);
        check_eq("b_de_lines", 32'(st.de_lines), 32'd8);
        check_eq("b_rgb_err", 32'(st.rgb_err), 32'd0);
        k = 0;
        while (!(cur.de && cur.x == 11'd5) && k < 500) begin
            prev = cur;
            step(1, cur);
            k++;
        end
        check_eq("b_reach_mid_line", 32'(cur.de && cur.x == 11'd5), 32'd1);
        @(negedge clock);
        rst_b = 1'b1;
        #1;
        cur = grab(1);
        check_eq("b_async_hs", 32'(cur.hs), 32'd0);
        check_eq("b_async_vs", 32'(cur.vs), 32'd1);
        check_eq("b_async_de", 32'(cur.de), 32'd0);
        check_eq("b_async_x", 32'(cur.x), 32'd0);
        check_eq("b_async_rgb", 32'(cur.rgb), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_b = 1'b0;
        k = 0;
        do begin
            prev = cur;
            step(1, cur);
            k++;
        end while (!cur.fs && k < 10);
        check_eq("b2_fs_edge", 32'(k), 32'd1);
        run_frame(1, c, -1, cur, prev, st);
        check_eq("b2_clocks", 32'(st.n_clk), 32'd448);
        check_eq("b2_hs_width", 32'(st.hs_run0), 32'd8);
        check_eq("b2_de_clk", 32'(st.de_clk), 32'd128);
        check_eq("b2_seq_err", 32'(st.seq_err), 32'd0);
        check_eq("b2_rgb_err", 32'(st.rgb_err), 32'd0);
        done_b = 1'b1;
    end

    // Summary once both generators are done
    initial begin : summary
        n_total = 0;
        n_bad   = 0;
        wait (done_a === 1'b1 && done_b === 1'b1);
        #20;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop if a sequence never completes
    initial begin : watchdog
        #1500000;
        n_bad++;
        $display("FAIL watchdog: got=timeout expected=completion");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing and test-pattern generator for the Spartan-3E board, driving the 8-bit RGB DAC and sync pins directly. It generalises the fixed 640x480 green-screen generator: timing, pixel-clock divide ratio and sync polarity are parameters; it adds four selectable patterns, proper blanking, a data-enable output, pixel coordinates and a frame-start strobe. It sits at the top of the video path and later feeds a frame-buffer reader through `x`, `y` and `de`.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; range 1..16.
- `H_SYNC`, 96: horizontal sync width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `H_ACT`, 640: active pixels per line; multiple of 8.
- `H_FP`, 16: horizontal front porch, pixels.
- `V_SYNC`, 2: vertical sync width, lines.
- `V_BP`, 33: vertical back porch, lines.
- `V_ACT`, 480: active lines.
- `V_FP`, 10: vertical front porch, lines.
- `HS_POL`, 0: active level of `hs`.
- `VS_POL`, 0: active level of `vs`.
- Each total, H_TOT = H_SYNC+H_BP+H_ACT+H_FP and V_TOT likewise, must be ≤ 2048.

- `clock`  in  1  system clock (50 MHz); single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  2  pattern select: 0 solid, 1 colour bars, 2 checker, 3 border.
- `solid_color`  in  8  {r[2:0], g[2:0], b[1:0]} used by modes 0 and 3.
- `hs`  out  1  horizontal sync.
- `vs`  out  1  vertical sync.
- `r`  out  3  red.
- `g`  out  3  green.
- `b`  out  2  blue.
- `de`  out  1  high during active video.
- `x`  out  11  active pixel column; 0 when `de`=0.
- `y`  out  11  active line; 0 when `de`=0.
- `frame_start`  out  1  one-`clock` pulse at the first pixel of each frame.

## Operation
- Divider `dc` counts 0..CLK_DIV-1. `pix_en`=1 when `dc`==CLK_DIV-1, or on every clock when CLK_DIV=1.
- Horizontal counter `hc` (0..H_TOT-1) advances on `pix_en` and wraps to 0. Vertical counter `vc` (0..V_TOT-1) advances when `hc` wraps and wraps to 0 after V_TOT-1.
- Line layout from `hc`=0: sync [0, H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT), front porch. The frame uses the same layout on `vc`.
- `hs` is at level HS_POL while `hc` < H_SYNC, otherwise at ~HS_POL. `vs` is at level VS_POL while `vc` < V_SYNC, otherwise at ~VS_POL.
- `de` = horizontal active AND vertical active. `x` = `hc`-(H_SYNC+H_BP) and `y` = `vc`-(V_SYNC+V_BP) when `de`=1, otherwise 0.
- `mode` and `solid_color` are captured into shadow registers when `hc`=0 and `vc`=0 on `pix_en`. A change takes effect at the next frame boundary, never mid-frame.
- Pattern (when `de`=1):
  - mode 0: `solid_color`.
  - mode 1: bar k = `x`/(H_ACT/8), k in 0..7. Colour index c=7-k; r={3{c[2]}}, g={3{c[1]}}, b={2{c[0]}}. Bar 0 is white, bar 7 is black. No divider: use comparisons against multiples of H_ACT/8.
  - mode 2: white (8'hFF) when `x`[5]^`y`[5] is 1, else black. This gives 32x32-pixel squares, white starting at `x`=32, `y`=0.
  - mode 3: white on `x`==0, `x`==H_ACT-1, `y`==0 or `y`==V_ACT-1; `solid_color` elsewhere.
- When `de`=0, r/g/b = 0 (blanking is mandatory).

## Timing
- All outputs are registered and update only on `pix_en` cycles, except `frame_start`, which is high for exactly one `clock`.
- Outputs decode the counter values current at that `pix_en` edge. `hs`, `vs`, `de`, `x`, `y` and RGB are mutually aligned with zero skew.
- Reset (asynchronous, takes effect immediately): `dc`=`hc`=`vc`=0, `hs`=~HS_POL, `vs`=~VS_POL, `de`=0, r=g=b=0, `x`=`y`=0, `frame_start`=0, shadow mode=0, shadow colour=0.
- After reset deasserts, the first `pix_en` is at the CLK_DIV-th rising edge. At that edge `hs` and `vs` go active, `frame_start` pulses and the shadow registers load.
- Line period = H_TOT×CLK_DIV clocks. Frame period = V_TOT×H_TOT×CLK_DIV clocks.
- Reset asserted mid-frame aborts the frame. Restart is identical to power-up; no partial line is emitted.

## Test plan
- Reset: hold `reset` high, check every output holds its reset value. Release it and check `hs`/`vs` go low and `frame_start` pulses at clock 2.
- Defaults, mode 0, solid_color=8'h1C: check line period 1600 clocks, `hs` low 192 clocks and `de` high 1280 clocks per line. Check 480 `de` lines per 525-line frame, `vs` low 2 lines, RGB = {0,7,0} when active and 0 when blanked.
- Mode 1: check RGB at `x`=0 is {7,7,3}, at `x`=80 is {7,7,0}, at `x`=639 is {0,0,0}. Check `x` sequences 0..639 without gaps.
- Mode 2 then mode 3 (solid_color=8'hE0): check (31,0) black and (32,0) white. Check border pixels (0,5) and (639,479) white and (5,5) = {7,0,0}.
- Switch `mode` 0→1 mid-frame at line 200: the rest of the frame stays solid; bars appear from the first active line of the next frame.
- CLK_DIV=1, HS_POL=1, reduced timing (8/4/16/4 by 2/2/8/2): check line = 32 clocks, frame = 14 lines, `hs` high for 8 clocks. Assert `reset` mid-line and check a clean restart.
